mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
Parametrised, pipelined N:1 multiplexer for datapath read selection, such as register-file read ports and forwarding selects. It is a binary tree of 2:1 mux levels with a pipeline register after every STAGE_LEVELS levels. A valid bit travels with each operand. A global stall freezes the pipeline and a flush kills in-flight operands.

Parameters:
WIDTH, 64, bits per input word and output word.
N, 32, number of inputs; must be a power of 2 and at least 2.
STAGE_LEVELS, 2, mux levels between pipeline registers; must be at least 1.
SELW, $clog2(N), select width; derived from N, not overridden.
LAT, ceil(SELW/STAGE_LEVELS), pipeline latency in cycles; derived.

Ports:
clk  input  1  clock; all registers update on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data/in_sel hold a valid operand this cycle.
in_data  input  N*WIDTH  word k occupies bits [k*WIDTH +: WIDTH].
in_sel  input  SELW  index of the word to select.
stall  input  1  freeze all pipeline registers.
flush  input  1  invalidate all in-flight operands.
in_ready  output  1  equals !stall; the input is accepted only when in_valid && in_ready.
out_valid  output  1  out_data holds a selected word.
out_data  output  WIDTH  the selected word.

Behaviour:
- Reset is asynchronous. While reset is high:
  - all stage valid bits are 0, so out_valid=0;
  - all stage data and select registers are 0, so out_data=0.
- Reset deasserting mid-operation leaves the pipe empty. Operands in flight at reset are lost.
- Tree structure:
  - Level j (j=0..SELW-1) reduces the candidate count by half using select bit j (LSB first).
  - A stage register follows levels STAGE_LEVELS-1, 2*STAGE_LEVELS-1, and so on, plus the last level.
  - This gives LAT register stages in total. The final stage drives out_data/out_valid directly, with no combinational path from inputs to outputs.
- Each stage register holds:
  - the surviving candidates, each WIDTH wide;
  - the select bits not yet consumed;
  - a valid bit.
- Latency: an operand accepted at edge t appears on out_data/out_valid after edge t+LAT-1, i.e. LAT cycles with no stall. Throughput is one operand per cycle.
- When stall=1 and flush=0, every stage register holds, including valid bits. out_data and out_valid stay constant, and the input is not captured.
- When flush=1, every stage valid bit is cleared at the next edge, regardless of stall. Flush wins over stall. Data registers may load or hold (don't-care), and the input presented that cycle is discarded.
- When in_valid=0 and stall=0, stage 0 loads valid=0. Its data is don't-care, but it must not propagate as valid.
- out_data while out_valid=0 is unspecified after reset. Benches check data only when out_valid=1.
- Since N is a power of 2, every in_sel value is legal, so no out-of-range case exists.
- Pure feed-forward with no backpressure beyond stall. The upstream must not drop an operand while in_ready=0.
- Degenerate configuration: N=2, STAGE_LEVELS=1 gives LAT=1, i.e. a single registered 2:1 mux.

Test Plan:
1. Defaults (LAT=3), in_data word k = 64'h1000+k, one valid operand with in_sel=5 -> after 3 edges out_valid=1, out_data=64'h1005; the next cycle out_valid=0.
2. Back-to-back in_sel=0,31,17,10 on consecutive cycles -> out_data 64'h1000, 64'h101F, 64'h1011, 64'h100A on 4 consecutive cycles starting at cycle 3, with out_valid continuously 1.
3. Stream in_sel=1,2,3 and assert stall for 2 cycles while 2 operands are in flight -> outputs frozen and in_ready=0 during the stall; sequence 64'h1001, 64'h1002, 64'h1003 arrives in order, delayed by 2 cycles, with none lost or duplicated.
4. Issue 3 operands, then assert flush together with stall for 1 cycle -> out_valid=0 for the next 3 cycles. An operand issued after the flush emerges correctly, 3 cycles later.
5. Assert reset asynchronously, between edges, with 2 operands in flight -> out_valid and out_data go to 0 immediately without a clock edge. After release, no stale operand emerges.
6. Parameter sweep N=2/STAGE_LEVELS=1, N=8/STAGE_LEVELS=3, and N=16/WIDTH=8/STAGE_LEVELS=2 -> latencies 1, 1, 2. Every in_sel is exhaustively correct against a reference model.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree: SELW levels of 2:1 muxes, one register stage every
// STAGE_LEVELS levels. Each stage carries surviving candidates, unused select bits and a valid bit.
module mux_tree_pipe #(
  parameter  int WIDTH        = 64,
  parameter  int N            = 32,
  parameter  int STAGE_LEVELS = 2,
  localparam int SELW         = $clog2(N),
  localparam int LAT          = (SELW + STAGE_LEVELS - 1) / STAGE_LEVELS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data
);

  assign in_ready = ~stall;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LV_IN  = s * STAGE_LEVELS;
    localparam int LV_OUT = (LV_IN + STAGE_LEVELS > SELW) ? SELW : LV_IN + STAGE_LEVELS;
    localparam int LVLS   = LV_OUT - LV_IN;
    localparam int CIN    = N >> LV_IN;
    localparam int COUT   = N >> LV_OUT;
    localparam int SIN    = SELW - LV_IN;
    localparam int SOUT   = SELW - LV_OUT;
    // Payload packs {remaining select bits, candidates}; the last stage is exactly WIDTH.
    localparam int PW     = SOUT + COUT * WIDTH;

    logic                  w_vin;
    logic [CIN*WIDTH-1:0]  w_din;
    logic [SIN-1:0]        w_sin;
    logic [COUT*WIDTH-1:0] w_words;
    logic [PW-1:0]         w_pnxt;
    logic                  r_vld;
    logic [PW-1:0]         r_pl;

    if (s == 0) begin : g_head
      assign w_vin = in_valid;
      assign w_din = in_data;
      assign w_sin = in_sel;
    end else begin : g_link
      assign w_vin = g_stage[s-1].r_vld;
      assign w_din = g_stage[s-1].r_pl[CIN*WIDTH-1:0];
      assign w_sin = g_stage[s-1].r_pl[SIN+CIN*WIDTH-1:CIN*WIDTH];
    end

    // LVLS cascaded 2:1 levels, LSB first, collapse to picking word k*2^LVLS + sel[LVLS-1:0].
    always_comb begin
      w_words = '0;
      for (int k = 0; k < COUT; k++)
        w_words[k*WIDTH +: WIDTH] = w_din[((k << LVLS) + int'(w_sin[LVLS-1:0]))*WIDTH +: WIDTH];
    end

    if (SOUT > 0) begin : g_sel
      assign w_pnxt = {w_sin[SIN-1:LVLS], w_words};
    end else begin : g_nosel
      assign w_pnxt = w_words;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_pl  <= '0;
      end else if (flush) begin
        r_vld <= 1'b0;
      end else if (!stall) begin
        r_vld <= w_vin;
        r_pl  <= w_pnxt;
      end
    end
  end

  assign out_valid = g_stage[LAT-1].r_vld;
  assign out_data  = g_stage[LAT-1].r_pl;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: directed scenarios and a randomized run on the default
// configuration, plus exhaustive select sweeps on three small configurations.
module tb_mux_tree_pipe;
  localparam int LAT_M = 3;
  localparam int LAT_A = 1;
  localparam int LAT_B = 1;
  localparam int LAT_C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, flush;
  int n_chk = 0;
  int n_fail = 0;

  logic m_v, m_rdy, m_ov;  logic [32*64-1:0] m_d; logic [4:0] m_s; logic [63:0] m_od;
  logic a_v, a_rdy, a_ov;  logic [2*64-1:0]  a_d; logic [0:0] a_s; logic [63:0] a_od;
  logic b_v, b_rdy, b_ov;  logic [8*64-1:0]  b_d; logic [2:0] b_s; logic [63:0] b_od;
  logic c_v, c_rdy, c_ov;  logic [16*8-1:0]  c_d; logic [3:0] c_s; logic [7:0]  c_od;

  logic [63:0] mw[32];
  logic [63:0] aw[2];
  logic [63:0] bw[8];
  logic [7:0]  cw[16];

  mux_tree_pipe u_main (.clk(clk), .reset(reset), .in_valid(m_v), .in_data(m_d), .in_sel(m_s),
    .stall(stall), .flush(flush), .in_ready(m_rdy), .out_valid(m_ov), .out_data(m_od));
  mux_tree_pipe #(.WIDTH(64), .N(2), .STAGE_LEVELS(1)) u_a (.clk(clk), .reset(reset),
    .in_valid(a_v), .in_data(a_d), .in_sel(a_s), .stall(stall), .flush(flush),
    .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od));
  mux_tree_pipe #(.WIDTH(64), .N(8), .STAGE_LEVELS(3)) u_b (.clk(clk), .reset(reset),
    .in_valid(b_v), .in_data(b_d), .in_sel(b_s), .stall(stall), .flush(flush),
    .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od));
  mux_tree_pipe #(.WIDTH(8), .N(16), .STAGE_LEVELS(2)) u_c (.clk(clk), .reset(reset),
    .in_valid(c_v), .in_data(c_d), .in_sel(c_s), .stall(stall), .flush(flush),
    .in_ready(c_rdy), .out_valid(c_ov), .out_data(c_od));

  typedef struct { logic [63:0] w; int age; } ent_t;
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_main();
    for (int k = 0; k < 32; k++) m_d[k*64 +: 64] = mw[k];
  endtask

  initial begin
    int s2[4];
    int idx;
    logic exp_ov;
    s2 = '{0, 31, 17, 10};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    m_v = 1'b0; m_s = '0; a_v = 1'b0; a_s = '0; b_v = 1'b0; b_s = '0; c_v = 1'b0; c_s = '0;
    for (int k = 0; k < 32; k++) mw[k] = 64'h1000 + 64'(k);
    pack_main();
    for (int k = 0; k < 2; k++)  begin aw[k] = {$urandom, $urandom}; a_d[k*64 +: 64] = aw[k]; end
    for (int k = 0; k < 8; k++)  begin bw[k] = {$urandom, $urandom}; b_d[k*64 +: 64] = bw[k]; end
    for (int k = 0; k < 16; k++) begin cw[k] = 8'($urandom);         c_d[k*8 +: 8]   = cw[k]; end

    // reset state
    #3;
    chk("rst_ov", m_ov, 0); chk("rst_od", m_od, 0); chk("rst_rdy", m_rdy, 1);
    chk("rst_a_ov", a_ov, 0); chk("rst_b_ov", b_ov, 0);
    chk("rst_c_ov", c_ov, 0); chk("rst_c_od", c_od, 0);
    reset = 1'b0;

    // single operand, latency 3
    m_v = 1'b1; m_s = 5'd5;
    tick(); m_v = 1'b0;
    chk("t1_e1_ov", m_ov, 0);
    tick(); chk("t1_e2_ov", m_ov, 0);
    tick(); chk("t1_e3_ov", m_ov, 1); chk("t1_e3_od", m_od, 64'h1005);
    tick(); chk("t1_e4_ov", m_ov, 0);

    // back-to-back
    for (int c = 0; c < 7; c++) begin
      m_v = (c < 4);
      m_s = (c < 4) ? 5'(s2[c]) : 5'd0;
      tick();
      if (c >= 2 && c <= 5) begin
        chk("t2_ov", m_ov, 1);
        chk("t2_od", m_od, 64'h1000 + 64'(s2[c-2]));
      end else chk("t2_ov_idle", m_ov, 0);
    end
    m_v = 1'b0;

    // stall with two operands in flight
    m_v = 1'b1; m_s = 5'd1; tick();
    m_s = 5'd2; tick();
    m_s = 5'd3; stall = 1'b1; tick();
    chk("t3_rdy", m_rdy, 0); chk("t3_a_rdy", a_rdy, 0); chk("t3_b_rdy", b_rdy, 0);
    chk("t3_c_rdy", c_rdy, 0); chk("t3_s1_ov", m_ov, 0);
    tick(); chk("t3_s2_ov", m_ov, 0);
    stall = 1'b0; tick();
    m_v = 1'b0;
    chk("t3_o1_ov", m_ov, 1); chk("t3_o1_od", m_od, 64'h1001);
    tick(); chk("t3_o2_ov", m_ov, 1); chk("t3_o2_od", m_od, 64'h1002);
    tick(); chk("t3_o3_ov", m_ov, 1); chk("t3_o3_od", m_od, 64'h1003);
    tick(); chk("t3_end_ov", m_ov, 0);

    // flush with stall kills everything in flight
    m_v = 1'b1; m_s = 5'd4; tick();
    m_s = 5'd5; tick();
    m_s = 5'd6; tick();
    chk("t4_pre_ov", m_ov, 1); chk("t4_pre_od", m_od, 64'h1004);
    m_s = 5'd7; flush = 1'b1; stall = 1'b1; tick();
    flush = 1'b0; stall = 1'b0;
    chk("t4_f1_ov", m_ov, 0);
    m_s = 5'd9; tick(); m_v = 1'b0;
    chk("t4_f2_ov", m_ov, 0);
    tick(); chk("t4_f3_ov", m_ov, 0);
    tick(); chk("t4_new_ov", m_ov, 1); chk("t4_new_od", m_od, 64'h1009);
    tick(); chk("t4_end_ov", m_ov, 0);

    // asynchronous reset mid-cycle
    m_v = 1'b1; m_s = 5'd12; tick();
    m_s = 5'd13; tick();
    m_s = 5'd14; tick(); m_v = 1'b0;
    chk("t5_pre_ov", m_ov, 1); chk("t5_pre_od", m_od, 64'h100C);
    #3 reset = 1'b1;
    #1;
    chk("t5_async_ov", m_ov, 0); chk("t5_async_od", m_od, 0);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(); chk("t5_post_ov", m_ov, 0);
    end

    // randomized run against an age-tracking scoreboard
    q.delete();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      m_v   = ($urandom_range(0, 3) != 0);
      m_s   = 5'($urandom_range(0, 31));
      for (int k = 0; k < 32; k++) mw[k] = {$urandom, $urandom};
      pack_main();
      if (flush) q.delete();
      else if (!stall) begin
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (m_v) q.push_back('{mw[m_s], 1});
        while (q.size() > 0 && q[0].age > LAT_M) void'(q.pop_front());
      end
      tick();
      exp_ov = (q.size() > 0) && (q[0].age == LAT_M);
      chk("rnd_ov", m_ov, exp_ov);
      if (exp_ov) chk("rnd_od", m_od, q[0].w);
    end
    stall = 1'b0; flush = 1'b0; m_v = 1'b0;
    tick(); tick(); tick();

    // exhaustive select sweeps on small configurations
    for (int c = 0; c < 19; c++) begin
      a_v = (c < 2);  a_s = 1'(c);
      b_v = (c < 8);  b_s = 3'(c);
      c_v = (c < 16); c_s = 4'(c);
      tick();
      idx = c - LAT_A + 1;
      if (idx >= 0 && idx < 2) begin chk("swA_ov", a_ov, 1); chk("swA_od", a_od, aw[idx]); end
      else chk("swA_idle", a_ov, 0);
      idx = c - LAT_B + 1;
      if (idx >= 0 && idx < 8) begin chk("swB_ov", b_ov, 1); chk("swB_od", b_od, bw[idx]); end
      else chk("swB_idle", b_ov, 0);
      idx = c - LAT_C + 1;
      if (idx >= 0 && idx < 16) begin chk("swC_ov", c_ov, 1); chk("swC_od", c_od, cw[idx]); end
      else chk("swC_idle", c_ov, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
